// File: rtl/seg7_scan_ctrl.sv
// Purpose: time-multiplexed common-anode hex display driver; new data is committed only at frame wrap.
// Latency: seg/an/frame_done are registered, one cycle behind the scan state; a load shows from the next frame.
// Backpressure: none; load is a fire-and-forget strobe. Optional leading-zero blanking via SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_MAX0 = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam int IDX_W    = $clog2((DIGITS > 2) ? DIGITS : 2);
    localparam bit HAS_BLANK = (BLANK_CYC > 0);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    localparam logic [0:0] SHOW  = 1'b0;
    localparam logic [0:0] BLANK = 1'b1;

    logic [0:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         idx;
    logic [DIGITS-1:0][3:0]   shadow;
    logic [DIGITS-1:0][3:0]   pend;
    logic                     pend_valid;
    logic                     wrap_q;

    logic                     slot_end;
    logic                     advance;
    logic                     wrap;
    logic [DIGITS-1:0]        lead_zero;
    logic                     upper_zero;
    logic                     show_digit;
    logic [3:0]               cur_nib;

    // active-low abcdefg hex glyphs
    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'h0: dec = 7'b0000001;
            4'h1: dec = 7'b1001111;
            4'h2: dec = 7'b0010010;
            4'h3: dec = 7'b0000110;
            4'h4: dec = 7'b1001100;
            4'h5: dec = 7'b0100100;
            4'h6: dec = 7'b0100000;
            4'h7: dec = 7'b0001111;
            4'h8: dec = 7'b0000000;
            4'h9: dec = 7'b0000100;
            4'hA: dec = 7'b0001000;
            4'hB: dec = 7'b1100000;
            4'hC: dec = 7'b0110001;
            4'hD: dec = 7'b1000010;
            4'hE: dec = 7'b0110000;
            default: dec = 7'b0111000;
        endcase
    endfunction

    // slot end, digit advance and frame wrap decode
    always_comb begin
        slot_end = (state == SHOW) ? (cnt == SHOW_LAST) : (cnt == BLANK_LAST);
        advance  = slot_end && ((state == BLANK) || !HAS_BLANK);
        wrap     = advance && (idx == IDX_LAST);
    end

    // leading-zero mask: lead_zero[i] set when nibbles i..top are all zero (digit 0 never blanked)
    always_comb begin
        lead_zero  = '0;
        upper_zero = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero   = upper_zero && (shadow[i] == 4'h0);
            lead_zero[i] = upper_zero;
        end
        lead_zero[0] = 1'b0;
`endif
    end

    // digit currently being presented, if any
    always_comb begin
        cur_nib    = shadow[idx];
        show_digit = (state == SHOW) && digit_en[idx] && !lead_zero[idx];
    end

    // scan FSM: dwell counter, SHOW/BLANK sequencing and round-robin digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SHOW;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            if (slot_end) cnt <= '0;
            else          cnt <= cnt + CNT_W'(1);
            if (state == SHOW && slot_end && HAS_BLANK) state <= BLANK;
            else if (state == BLANK && slot_end)        state <= SHOW;
            if (advance) idx <= wrap ? '0 : idx + IDX_W'(1);
        end
    end

    // load capture into pend; shadow commits only on the wrap cycle (a load on wrap wins over pend)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow     <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (wrap) begin
            if (load)            shadow <= data;
            else if (pend_valid) shadow <= pend;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend       <= data;
            pend_valid <= 1'b1;
        end
    end

    // registered pin drive; frame_done delayed twice so it lines up with the first digit-0 output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= 7'h7F;
            an         <= '1;
            wrap_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wrap_q     <= wrap;
            frame_done <= wrap_q;
            if (show_digit) begin
                an  <= ~(DIGITS'(1) << idx);
                seg <= dec(cur_nib);
            end else begin
                an  <= '1;
                seg <= 7'h7F;
            end
        end
    end

endmodule
